// File: rtl/floppy_mech.sv
// Floppy drive mechanics model for up to four drives.
// Consumes CIA-B port B (active-low MTR/SEL/SIDE/DIR/STEP), tracks per-drive
// motor, cylinder and disk-change state, and returns drive status, the index
// pulse and head position. Optional macro DRIVE_ID_EN enables the serial
// drive-ID readout on _RDY while a selected drive's motor is off.
module floppy_mech #(
  parameter int NDRIVES      = 4,
  parameter int TRACKS       = 80,
  parameter int INDEX_PERIOD = 1418758,
  parameter int INDEX_WIDTH  = 64
) (
  input  logic       clk,
  input  logic       clk7_en,
  input  logic       reset,
  input  logic [7:0] prb,
  input  logic [3:0] disk_present,
  input  logic [3:0] wr_prot,
  output logic       drv_rdy_n,
  output logic       drv_tk0_n,
  output logic       drv_wpro_n,
  output logic       drv_chng_n,
  output logic       index,
  output logic       sel_valid,
  output logic [1:0] sel_drive,
  output logic [6:0] track,
  output logic       side,
  output logic [3:0] motor
);

  localparam int         CNT_W     = $clog2(INDEX_PERIOD + 1);
  localparam logic [6:0] TRACK_MAX = 7'(TRACKS - 1);

  logic [7:0]       prb_q;
  logic [3:0]       motor_r;
  logic [3:0]       chng_r;
  logic [6:0]       cyl_r [4];
  logic [CNT_W-1:0] idx_cnt;

  logic [3:0] populated;
  logic [3:0] sel_fall;
  logic [3:0] step_hit;
  logic       step_rise;
  logic       sel_any;
  logic [1:0] sel_num;
  logic       nxt_rdy_n, nxt_tk0_n, nxt_wpro_n, nxt_chng_n, nxt_index;

`ifdef DRIVE_ID_EN
  localparam logic [31:0] DRIVE_ID = 32'hFFFF_FFFF;  // 3.5" DD
  logic [4:0] id_idx [4];
`endif

  // Edge detection against the registered port and per-drive step targets.
  always_comb begin
    step_rise = ~prb_q[0] & prb[0];
    for (int x = 0; x < 4; x++) begin
      populated[x] = (x < NDRIVES);
      sel_fall[x]  = populated[x] & prb_q[3+x] & ~prb[3+x];
      step_hit[x]  = step_rise & populated[x] & ~prb_q[3+x];
    end
  end

  // Lowest-numbered populated drive with _SEL low wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_any = 1'b0;
    sel_num = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (populated[i] && !prb_q[3+i]) begin
        sel_any = 1'b1;
        sel_num = 2'(i);
      end
    end
  end

  // Status of the selected drive, registered into the outputs next tick.
  always_comb begin
    nxt_rdy_n  = 1'b1;
    nxt_tk0_n  = 1'b1;
    nxt_wpro_n = 1'b1;
    nxt_chng_n = 1'b1;
    nxt_index  = 1'b0;
    if (sel_any) begin
      nxt_rdy_n  = ~(motor_r[sel_num] & disk_present[sel_num]);
      nxt_tk0_n  = (cyl_r[sel_num] != 7'd0);
      nxt_wpro_n = ~(disk_present[sel_num] & wr_prot[sel_num]);
      nxt_chng_n = ~chng_r[sel_num];
      nxt_index  = (idx_cnt < CNT_W'(INDEX_WIDTH)) & motor_r[sel_num]
                   & disk_present[sel_num];
`ifdef DRIVE_ID_EN
      if (!motor_r[sel_num] && sel_num != 2'd0)
        nxt_rdy_n = ~DRIVE_ID[5'd31 - id_idx[sel_num]];
`endif
    end
  end

  // Mechanical state: port register, motors, cylinders, change latches, index counter.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        prb_q   <= 8'hFF;
        motor_r <= 4'h0;
        chng_r  <= 4'hF;
        idx_cnt <= '0;
        // NOTE: the cylinder array is a few flops rather than a RAM, so it is reset like any register.
        for (int x = 0; x < 4; x++) begin
          cyl_r[x] <= 7'd0;
`ifdef DRIVE_ID_EN
          id_idx[x] <= 5'd0;
`endif
        end
      end else begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values.
        prb_q <= prb;
        for (int x = 0; x < 4; x++) begin
          if (sel_fall[x]) begin
            motor_r[x] <= ~prb[7];
`ifdef DRIVE_ID_EN
            if (prb[7]) id_idx[x] <= motor_r[x] ? 5'd0 : id_idx[x] + 5'd1;
`endif
          end
          if (step_hit[x]) begin
            if (prb_q[1]) begin
              if (cyl_r[x] != 7'd0) cyl_r[x] <= cyl_r[x] - 7'd1;
            end else begin
              if (cyl_r[x] != TRACK_MAX) cyl_r[x] <= cyl_r[x] + 7'd1;
            end
          end
          if (!disk_present[x])                chng_r[x] <= 1'b1;
          else if (step_hit[x])                chng_r[x] <= 1'b0;
        end
        if (motor_r == 4'h0)                        idx_cnt <= '0;
        else if (idx_cnt == CNT_W'(INDEX_PERIOD-1)) idx_cnt <= '0;
        else                                        idx_cnt <= idx_cnt + 1'b1;
      end
    end
  end

  // Registered outputs derived from the mechanical state.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        drv_rdy_n  <= 1'b1;
        drv_tk0_n  <= 1'b1;
        drv_wpro_n <= 1'b1;
        drv_chng_n <= 1'b1;
        index      <= 1'b0;
        sel_valid  <= 1'b0;
        sel_drive  <= 2'd0;
        track      <= 7'd0;
        side       <= 1'b0;
        motor      <= 4'h0;
      end else begin
        drv_rdy_n  <= nxt_rdy_n;
        drv_tk0_n  <= nxt_tk0_n;
        drv_wpro_n <= nxt_wpro_n;
        drv_chng_n <= nxt_chng_n;
        index      <= nxt_index;
        sel_valid  <= sel_any;
        sel_drive  <= sel_num;
        track      <= cyl_r[sel_num];
        side       <= ~prb_q[2];
        motor      <= motor_r;
      end
    end
  end

endmodule

// File: tb/tb_floppy_mech.sv
// Self-checking bench for floppy_mech: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against an
// event-level behavioural model of the drive mechanics.
module tb_floppy_mech;

  localparam int ND = 3;
  localparam int T  = 80;
  localparam int P  = 100;
  localparam int W  = 4;

  logic       clk = 1'b0;
  logic       clk7_en = 1'b1;
  logic       reset = 1'b1;
  logic [7:0] prb = 8'hFF;
  logic [3:0] disk_present = 4'h0;
  logic [3:0] wr_prot = 4'h0;
  logic       drv_rdy_n, drv_tk0_n, drv_wpro_n, drv_chng_n, index, sel_valid, side;
  logic [1:0] sel_drive;
  logic [6:0] track;
  logic [3:0] motor;

  int checks = 0;
  int errors = 0;

  floppy_mech #(.NDRIVES(ND), .TRACKS(T), .INDEX_PERIOD(P), .INDEX_WIDTH(W)) dut (
    .clk(clk), .clk7_en(clk7_en), .reset(reset), .prb(prb),
    .disk_present(disk_present), .wr_prot(wr_prot),
    .drv_rdy_n(drv_rdy_n), .drv_tk0_n(drv_tk0_n), .drv_wpro_n(drv_wpro_n),
    .drv_chng_n(drv_chng_n), .index(index), .sel_valid(sel_valid),
    .sel_drive(sel_drive), .track(track), .side(side), .motor(motor)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_prbq;
  bit   m_motor [4];
  bit   m_chng  [4];
  int   m_cyl   [4];
  int   m_id    [4];
  int   m_cnt;
  bit   mvalid = 0;
  logic e_rdy_n, e_tk0_n, e_wpro_n, e_chng_n, e_index, e_sel_valid, e_side;
  logic [1:0] e_sel_drive;
  logic [6:0] e_track;
  logic [3:0] e_motor;

  function automatic int lowest_sel(input logic [7:0] p);
    for (int x = 0; x < ND; x++) if (!p[3+x]) return x;
    return -1;
  endfunction

  task automatic model_step();
    int s, sd;
    bit any_on;
    logic [31:0] id_word;
    id_word = 32'hFFFF_FFFF;
    if (reset) begin
      m_prbq = 8'hFF; m_cnt = 0;
      for (int x = 0; x < 4; x++) begin
        m_motor[x] = 0; m_chng[x] = 1; m_cyl[x] = 0; m_id[x] = 0;
      end
      {e_rdy_n, e_tk0_n, e_wpro_n, e_chng_n} = 4'hF;
      e_index = 0; e_sel_valid = 0; e_sel_drive = 0; e_track = 0; e_side = 0; e_motor = 0;
      mvalid = 1;
      return;
    end
    // outputs reflect state as it stood before this tick
    s  = lowest_sel(m_prbq);
    sd = (s >= 0) ? s : 0;
    e_sel_valid = (s >= 0);
    e_sel_drive = 2'(sd);
    e_track     = 7'(m_cyl[sd]);
    e_side      = !m_prbq[2];
    e_motor     = {m_motor[3], m_motor[2], m_motor[1], m_motor[0]};
    {e_rdy_n, e_tk0_n, e_wpro_n, e_chng_n} = 4'hF;
    e_index = 0;
    if (s >= 0) begin
      e_rdy_n  = !(m_motor[s] && disk_present[s]);
`ifdef DRIVE_ID_EN
      if (!m_motor[s] && s != 0) e_rdy_n = !id_word[31 - m_id[s]];
`endif
      e_tk0_n  = (m_cyl[s] != 0);
      e_wpro_n = !(disk_present[s] && wr_prot[s]);
      e_chng_n = !m_chng[s];
      e_index  = (m_cnt < W) && m_motor[s] && disk_present[s];
    end
    any_on = m_motor[0] || m_motor[1] || m_motor[2] || m_motor[3];
    // state update
    for (int x = 0; x < ND; x++) begin
      if (m_prbq[3+x] && !prb[3+x]) begin
        if (prb[7]) m_id[x] = m_motor[x] ? 0 : (m_id[x] + 1) % 32;
        m_motor[x] = !prb[7];
      end
    end
    if (!m_prbq[0] && prb[0]) begin
      for (int x = 0; x < ND; x++) begin
        if (!m_prbq[3+x]) begin
          if (m_prbq[1]) m_cyl[x] = (m_cyl[x] > 0) ? m_cyl[x] - 1 : 0;
          else           m_cyl[x] = (m_cyl[x] < T-1) ? m_cyl[x] + 1 : T-1;
          if (disk_present[x]) m_chng[x] = 0;
        end
      end
    end
    for (int x = 0; x < 4; x++) if (!disk_present[x]) m_chng[x] = 1;
    m_cnt  = any_on ? (m_cnt + 1) % P : 0;
    m_prbq = prb;
  endtask

  // Compare process: advance the model on each enabled edge, then check all outputs.
  always begin
    @(posedge clk);
    #1;
    if (clk7_en) model_step();
    if (mvalid) begin
      check("rdy_n",     32'(drv_rdy_n),  32'(e_rdy_n));
      check("tk0_n",     32'(drv_tk0_n),  32'(e_tk0_n));
      check("wpro_n",    32'(drv_wpro_n), 32'(e_wpro_n));
      check("chng_n",    32'(drv_chng_n), 32'(e_chng_n));
      check("index",     32'(index),      32'(e_index));
      check("sel_valid", 32'(sel_valid),  32'(e_sel_valid));
      check("sel_drive", 32'(sel_drive),  32'(e_sel_drive));
      check("track",     32'(track),      32'(e_track));
      check("side",      32'(side),       32'(e_side));
      check("motor",     32'(motor),      32'(e_motor));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] lo, input int n);
    for (int i = 0; i < n; i++) begin
      prb = lo; tick(1);
      prb = lo | 8'h01; tick(1);
    end
  endtask

  int highs;

  initial begin
    // reset with everything deselected
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_status", 32'({drv_rdy_n, drv_tk0_n, drv_wpro_n, drv_chng_n}), 32'hF);
    check("rst_motor",  32'(motor), 32'h0);
    check("rst_index",  32'(index), 32'h0);
    check("rst_track",  32'(track), 32'h0);
    check("rst_selv",   32'(sel_valid), 32'h0);

    // select drive 0 with motor on
    disk_present = 4'h1;
    prb = 8'h77;
    tick(2);
    check("sel0_motor", 32'(motor), 32'h1);
    check("sel0_drive", 32'(sel_drive), 32'h0);
    check("sel0_rdy",   32'(drv_rdy_n), 32'h0);
    check("sel0_chng",  32'(drv_chng_n), 32'h0);
    check("sel0_tk0",   32'(drv_tk0_n), 32'h0);

    // five steps inward, first one clears the change latch
    pulse(8'h74, 1);
    tick(1);
    check("step1_track", 32'(track), 32'd1);
    check("step1_chng",  32'(drv_chng_n), 32'h1);
    pulse(8'h74, 4);
    tick(1);
    check("step5_track", 32'(track), 32'd5);
    check("step5_tk0",   32'(drv_tk0_n), 32'h1);
    // seven steps outward saturate at 0
    pulse(8'h76, 7);
    tick(1);
    check("out_track", 32'(track), 32'd0);
    check("out_tk0",   32'(drv_tk0_n), 32'h0);
    // 85 steps inward saturate at TRACKS-1
    pulse(8'h74, 85);
    tick(1);
    check("in_track", 32'(track), 32'd79);
    disk_present = 4'h0;
    tick(2);
    check("eject_chng", 32'(drv_chng_n), 32'h0);
    check("eject_rdy",  32'(drv_rdy_n), 32'h1);

    // index: motor on, disk in -> W highs every P ticks
    disk_present = 4'h1;
    tick(2);
    highs = 0;
    for (int i = 0; i < 2*P; i++) begin
      tick(1);
      if (index) highs++;
    end
    check("index_highs", 32'(highs), 32'(2*W));
    // motor off via select edge with MTR high
    prb = 8'hFF; tick(1);
    prb = 8'hF7; tick(3);
    check("moff_motor", 32'(motor), 32'h0);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      tick(1);
      if (index) highs++;
    end
    check("moff_index", 32'(highs), 32'd0);

    // drive ID readout: drive 1 motor on then off, then 32 select cycles
    prb = 8'hFF; tick(1);
    prb = 8'h6F; tick(1);
    prb = 8'hFF; tick(1);
    prb = 8'hEF; tick(1);
    for (int i = 0; i < 32; i++) begin
      prb = 8'hFF; tick(1);
      prb = 8'hEF; tick(2);
`ifdef DRIVE_ID_EN
      check("id_d1", 32'(drv_rdy_n), 32'h0);
`else
      check("id_d1", 32'(drv_rdy_n), 32'h1);
`endif
    end
    for (int i = 0; i < 4; i++) begin
      prb = 8'hFF; tick(1);
      prb = 8'hF7; tick(2);
      check("id_d0", 32'(drv_rdy_n), 32'h1);
    end
    // unpopulated drive 3 is ignored
    prb = 8'hFF; tick(1);
    prb = 8'h3F; tick(2);
    check("d3_selv",  32'(sel_valid), 32'h0);
    check("d3_motor", 32'(motor), 32'h0);

    // randomized traffic with gapped clock enable
    for (int i = 0; i < 4000; i++) begin
      clk7_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) prb = prb ^ (8'h1 << $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) disk_present = 4'($urandom);
      if ($urandom_range(0, 31) == 0) wr_prot = 4'($urandom);
      reset = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    reset = 1'b0;
    clk7_en = 1'b1;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
